// File: rtl/fp_round_pipe.sv
// fp_round_pipe: two-stage rounding pipeline for the fp multiplier datapath.
// Stage 1 normalises the raw significand product by at most one position and
// splits it into kept bits, guard and sticky. Stage 2 applies the rounding mode
// and produces the stored mantissa, exponent adjustment and inexact flag.
// A valid/ready handshake with collapsing bubbles allows full-rate streaming
// under back-pressure with at most two beats in flight.
module fp_round_pipe #(
  parameter int IN_W  = 22,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_num,
  input  logic             in_sign,
  input  logic [2:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAN_W-1:0] out_man,
  output logic [1:0]       out_exp_adj,
  output logic             out_inexact,
  output logic [TAG_W-1:0] out_tag
);

  // Encodings 5-7 are not listed here and fall into the RNE default.
  typedef enum logic [2:0] {
    MODE_RNE = 3'd0,
    MODE_RTZ = 3'd1,
    MODE_RUP = 3'd2,
    MODE_RDN = 3'd3,
    MODE_RNA = 3'd4
  } roundMode_t;

  // The parameters must satisfy IN_W >= MAN_W + 3 so that at least one
  // sticky bit exists below the guard bit.

  // Pipeline occupancy
  logic r_v1;
  logic r_v2;

  // Stage 1 registers
  logic [MAN_W:0]     r_s1Kept;
  logic               r_s1Guard;
  logic               r_s1Sticky;
  logic               r_s1Nrm;
  logic               r_s1Sign;
  logic [2:0]         r_s1Mode;
  logic [TAG_W-1:0]   r_s1Tag;

  // Output registers
  logic [MAN_W-1:0]   r_outMan;
  logic [1:0]         r_outExpAdj;
  logic               r_outInexact;
  logic [TAG_W-1:0]   r_outTag;

  // Handshake wires
  logic w_s1En;
  logic w_s2En;

  // Stage 1 combinational wires
  logic [IN_W-1:0]    w_norm;
  logic [MAN_W:0]     w_kept;
  logic               w_guard;
  logic               w_sticky;

  // Stage 2 combinational wires
  logic               w_inc;
  logic               w_carry;
  logic [MAN_W-1:0]   w_manSum;
  logic [MAN_W-1:0]   w_manNext;
  logic [1:0]         w_expAdjNext;
  logic               w_inexactNext;

  // A stage can load when it is empty or when its content moves on this
  // cycle; an empty output stage therefore pulls stage 1 forward even while
  // downstream is stalled, which collapses bubbles.
  assign w_s2En   = ~r_v2 | out_ready;
  assign w_s1En   = ~r_v1 | w_s2En;
  assign in_ready = w_s1En;

  // Shift left once when the overflow position is clear so the hidden bit
  // always lands at the top of w_norm.
  assign w_norm   = in_num[IN_W-1] ? in_num : {in_num[IN_W-2:0], 1'b0};
  assign w_kept   = w_norm[IN_W-1 -: MAN_W+1];
  assign w_guard  = w_norm[IN_W-2-MAN_W];
  assign w_sticky = |w_norm[IN_W-3-MAN_W:0];

  // Select the round-up increment from guard, sticky, kept lsb and sign.
  always_comb begin
    w_inc = 1'b0;
    case (r_s1Mode)
      MODE_RTZ: w_inc = 1'b0;
      MODE_RUP: w_inc = (r_s1Guard | r_s1Sticky) & ~r_s1Sign;
      MODE_RDN: w_inc = (r_s1Guard | r_s1Sticky) & r_s1Sign;
      MODE_RNA: w_inc = r_s1Guard;
      default:  w_inc = r_s1Guard & (r_s1Sticky | r_s1Kept[0]);
    endcase
  end

  // Adding the increment to the kept bits carries out of the top only when
  // every kept bit is one, which is then a round-up to the next binade.
  assign w_carry       = (&r_s1Kept) & w_inc;
  assign w_manSum      = r_s1Kept[MAN_W-1:0] + {{(MAN_W-1){1'b0}}, w_inc};
  assign w_manNext     = w_carry ? '0 : w_manSum;
  assign w_expAdjNext  = {1'b0, r_s1Nrm} + {1'b0, w_carry};
  assign w_inexactNext = r_s1Guard | r_s1Sticky;

  // Stage 1: capture normalised fields and sideband for each accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1       <= 1'b0;
      r_s1Kept   <= '0;
      r_s1Guard  <= 1'b0;
      r_s1Sticky <= 1'b0;
      r_s1Nrm    <= 1'b0;
      r_s1Sign   <= 1'b0;
      r_s1Mode   <= '0;
      r_s1Tag    <= '0;
    end else begin
      if (w_s1En) begin
        r_v1 <= in_valid;
      end
      if (in_valid & w_s1En) begin
        r_s1Kept   <= w_kept;
        r_s1Guard  <= w_guard;
        r_s1Sticky <= w_sticky;
        r_s1Nrm    <= in_num[IN_W-1];
        r_s1Sign   <= in_sign;
        r_s1Mode   <= in_mode;
        r_s1Tag    <= in_tag;
      end
    end
  end

  // Stage 2: register rounded results; they hold while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2         <= 1'b0;
      r_outMan     <= '0;
      r_outExpAdj  <= '0;
      r_outInexact <= 1'b0;
      r_outTag     <= '0;
    end else begin
      if (w_s2En) begin
        r_v2 <= r_v1;
      end
      if (w_s2En & r_v1) begin
        r_outMan     <= w_manNext;
        r_outExpAdj  <= w_expAdjNext;
        r_outInexact <= w_inexactNext;
        r_outTag     <= r_s1Tag;
      end
    end
  end

  assign out_valid   = r_v2;
  assign out_man     = r_outMan;
  assign out_exp_adj = r_outExpAdj;
  assign out_inexact = r_outInexact;
  assign out_tag     = r_outTag;

endmodule
